// File: rtl/mac_result_fifo.sv
// mac_result_fifo: first-word-fall-through result buffer behind the MAC stage.
// Captures every result qualified by validi and presents it over a
// valid/ready handshake. Results arriving while full are dropped (never
// overwritten), recorded by a sticky overflow flag and a saturating counter.
//
// Ports:
//   clk, rst_      clock, asynchronous active-low reset
//   clr            synchronous clear, same effect as reset, highest priority
//   validi/data_in result from the MAC
//   out_valid/out_ready/out_data  consumer handshake (out_data is 0 when empty)
//   count/full/empty              occupancy status
//   overflow/drop_cnt             drop reporting
module mac_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DROPW = 8
) (
  input  logic                     clk,
  input  logic                     rst_,
  input  logic                     clr,
  input  logic                     validi,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic [DROPW-1:0]         drop_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic [DROPW-1:0] drop_cnt_q, drop_cnt_d;

  logic push, pop, drop;

  // Occupancy from pointer difference; the extra MSB separates full from empty.
  assign count     = wptr_q - rptr_q;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (count == '0);
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  assign pop  = out_valid && out_ready;
  // A pop frees the slot in the same edge, so a full buffer still accepts.
  assign push = validi && (!full || pop);
  assign drop = validi && full && !pop;

  // Next-state: clear wins over push, pop and drop.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clr) begin
      wptr_d     = '0;
      rptr_d     = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROPW'(1);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (!clr && push) mem_q[wptr_q[AW-1:0]] <= data_in;
  end

endmodule

// File: tb/tb_mac_result_fifo.sv
// Self-checking bench for mac_result_fifo (DEPTH=4, WIDTH=32, DROPW=2).
module tb_mac_result_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned DROPW = 2;

  logic             clk = 1'b0;
  logic             rst_;
  logic             clr;
  logic             validi;
  logic [WIDTH-1:0] data_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic             overflow;
  logic [DROPW-1:0] drop_cnt;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        vi;
    logic        rdy;
    logic        cl;
    logic [31:0] d;
    int          e_cnt;
    logic [31:0] e_dat;
    logic        e_ovf;
    int          e_drp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mac_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DROPW(DROPW)) dut (
    .clk(clk), .rst_(rst_), .clr(clr), .validi(validi), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every status output against one expected state.
  task automatic chk_state(input string tag, input int e_cnt, input logic [31:0] e_dat,
                           input logic e_ovf, input int e_drp);
    n_vec++;
    chk({tag, ".count"},     32'(count),     32'(e_cnt));
    chk({tag, ".empty"},     32'(empty),     32'(e_cnt == 0));
    chk({tag, ".full"},      32'(full),      32'(e_cnt == DEPTH));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_cnt != 0));
    chk({tag, ".out_data"},  out_data,       e_dat);
    chk({tag, ".overflow"},  32'(overflow),  32'(e_ovf));
    chk({tag, ".drop_cnt"},  32'(drop_cnt),  32'(e_drp));
  endtask

  task automatic add(input logic vi, input logic rdy, input logic cl, input logic [31:0] d,
                     input int e_cnt, input logic [31:0] e_dat, input logic e_ovf,
                     input int e_drp);
    vec_t v;
    v.vi = vi; v.rdy = rdy; v.cl = cl; v.d = d;
    v.e_cnt = e_cnt; v.e_dat = e_dat; v.e_ovf = e_ovf; v.e_drp = e_drp;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic drive(input logic vi, input logic rdy, input logic cl, input logic [31:0] d);
    validi = vi; out_ready = rdy; clr = cl; data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ = 1'b0; clr = 1'b0; validi = 1'b0; out_ready = 1'b0; data_in = '0;

    // Push then drain
    add(1, 0, 0, 32'd5, 1, 32'd5, 0, 0);
    add(1, 0, 0, 32'd7, 2, 32'd5, 0, 0);
    add(1, 0, 0, 32'd9, 3, 32'd5, 0, 0);
    add(0, 1, 0, 32'd0, 2, 32'd7, 0, 0);
    add(0, 1, 0, 32'd0, 1, 32'd9, 0, 0);
    add(0, 1, 0, 32'd0, 0, 32'd0, 0, 0);
    add(0, 1, 0, 32'd0, 0, 32'd0, 0, 0);   // ready while empty: no effect
    // Fill and overflow
    add(1, 0, 0, 32'd1, 1, 32'd1, 0, 0);
    add(1, 0, 0, 32'd2, 2, 32'd1, 0, 0);
    add(1, 0, 0, 32'd3, 3, 32'd1, 0, 0);
    add(1, 0, 0, 32'd4, 4, 32'd1, 0, 0);
    add(1, 0, 0, 32'd5, 4, 32'd1, 1, 1);
    add(1, 0, 0, 32'd6, 4, 32'd1, 1, 2);
    // Full simultaneous push/pop: no drop
    add(1, 1, 0, 32'hAA, 4, 32'd2, 1, 2);
    add(0, 1, 0, 32'd0, 3, 32'd3, 1, 2);
    add(0, 1, 0, 32'd0, 2, 32'd4, 1, 2);
    add(0, 1, 0, 32'd0, 1, 32'hAA, 1, 2);
    add(0, 1, 0, 32'd0, 0, 32'd0, 1, 2);
    // Push with ready while empty: push alone
    add(1, 1, 0, 32'h11, 1, 32'h11, 1, 2);
    add(0, 1, 0, 32'd0, 0, 32'd0, 1, 2);
    // Saturation: three more drops take drop_cnt 2 -> 3 -> 3 -> 3
    add(1, 0, 0, 32'h21, 1, 32'h21, 1, 2);
    add(1, 0, 0, 32'h22, 2, 32'h21, 1, 2);
    add(1, 0, 0, 32'h23, 3, 32'h21, 1, 2);
    add(1, 0, 0, 32'h24, 4, 32'h21, 1, 2);
    add(1, 0, 0, 32'h25, 4, 32'h21, 1, 3);
    add(1, 0, 0, 32'h26, 4, 32'h21, 1, 3);
    add(1, 0, 0, 32'h27, 4, 32'h21, 1, 3);
    // Clear with coincident push: push lost, all state cleared
    add(1, 1, 1, 32'h55, 0, 32'd0, 0, 0);
    add(0, 0, 0, 32'd0, 0, 32'd0, 0, 0);
    add(1, 0, 0, 32'h66, 1, 32'h66, 0, 0);
    add(0, 1, 0, 32'd0, 0, 32'd0, 0, 0);

    // Release reset between edges and check the reset state
    #12;
    chk_state("reset_hold", 0, 32'd0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    chk_state("post_reset", 0, 32'd0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].vi, vecs[i].rdy, vecs[i].cl, vecs[i].d);
      chk_state($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_dat,
                vecs[i].e_ovf, vecs[i].e_drp);
    end

    // Streaming: one result per cycle, each visible one cycle after arrival
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'(i));
      chk_state($sformatf("stream%0d", i), 1, 32'(i), 0, 0);
    end
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk_state("stream_end", 0, 32'd0, 0, 0);

    // Asynchronous reset while holding 3 entries after an overflow
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 32'(32'h40 + i));
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    chk_state("pre_reset", 3, 32'h41, 1, 1);
    validi = 1'b0; out_ready = 1'b0;
    #3;
    rst_ = 1'b0;
    #1;
    chk_state("async_reset", 0, 32'd0, 0, 0);
    @(negedge clk);
    rst_ = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h77);
    chk_state("after_reset_push", 1, 32'h77, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
